// File: rtl/wb_rr_arbiter_pkg.sv
// Shared Wishbone bus widths and arbiter defaults.
// Imported by the arbiter top and its round-robin picker.
package wb_rr_arbiter_pkg;

    localparam int WB_ADR_WIDTH = 32;
    localparam int WB_DAT_WIDTH = 32;
    localparam int WB_SEL_WIDTH = 4;

    localparam int WB_TIMEOUT_DEFAULT = 255;

    // Counter width for the optional watchdog.
    localparam int WB_TMO_CNT_W = 16;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Ports: req_i request vector, ptr_i last winner;
//        gnt_o one-hot winner, idx_o winner index,
//        valid_o set when any request is present.
// Scan starts at ptr_i+1 and wraps at N-1 -> 0.
module rr_pick
    import wb_rr_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    logic [PW-1:0] j;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = '0;
        // Offset N wraps back to ptr itself, so the
        // previous winner is checked last.
        for (int i = 1; i <= N; i++) begin
            j = PW'((int'(ptr_i) + i) % N);
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: shares one
// intercon master port between MASTER_NUM masters.
// Ports: clk_i, rst_i (async, active-low);
//   m_* per-master request side (packed, master 0 in LSBs),
//   m_ack_o/m_err_o per master, m_dat_o broadcast;
//   s_* single intercon port; gnt_o one-hot grant.
// Grant is held for the whole cyc of the winner, with
// one idle cycle between grants.
// Optional: define WB_ARB_TIMEOUT_EN to add a watchdog
// that errors out a stalled transfer after
// TIMEOUT_CYCLES stb cycles and releases the grant.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int MASTER_NUM     = 2,
    parameter int ADR_WIDTH      = WB_ADR_WIDTH,
    parameter int DAT_WIDTH      = WB_DAT_WIDTH,
    parameter int SEL_WIDTH      = WB_SEL_WIDTH,
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [MASTER_NUM-1:0]     m_cyc_i,
    input  logic [MASTER_NUM-1:0]     m_stb_i,
    input  logic [MASTER_NUM-1:0]     m_we_i,
    input  logic [MASTER_NUM*ADR_WIDTH-1:0] m_adr_i,
    input  logic [MASTER_NUM*DAT_WIDTH-1:0] m_dat_i,
    input  logic [MASTER_NUM*SEL_WIDTH-1:0] m_sel_i,
    output logic [MASTER_NUM-1:0]     m_ack_o,
    output logic [MASTER_NUM-1:0]     m_err_o,
    output logic [DAT_WIDTH-1:0]      m_dat_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [ADR_WIDTH-1:0]      s_adr_o,
    output logic [DAT_WIDTH-1:0]      s_dat_o,
    output logic [SEL_WIDTH-1:0]      s_sel_o,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic [DAT_WIDTH-1:0]      s_dat_i,
    output logic [MASTER_NUM-1:0]     gnt_o
);

    localparam int PW = ptr_width(MASTER_NUM);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t state, state_nxt;

    // In GRANT, ptr doubles as the granted index.
    logic [PW-1:0]         ptr, ptr_nxt;
    logic [MASTER_NUM-1:0] gnt, gnt_nxt;

    logic [MASTER_NUM-1:0] pick_gnt;
    logic [PW-1:0]         pick_idx;
    logic                  pick_vld;

    logic stb_raw;
    logic tmo;

    logic [ADR_WIDTH-1:0] adr_a [MASTER_NUM];
    logic [DAT_WIDTH-1:0] dat_a [MASTER_NUM];
    logic [SEL_WIDTH-1:0] sel_a [MASTER_NUM];

    for (genvar k = 0; k < MASTER_NUM; k++) begin : g_unpack
        assign adr_a[k] = m_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
        assign dat_a[k] = m_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
        assign sel_a[k] = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
    end

    rr_pick #(
        .N  (MASTER_NUM),
        .PW (PW)
    ) u_pick (
        .req_i   (m_cyc_i),
        .ptr_i   (ptr),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

`ifdef WB_ARB_TIMEOUT_EN
    logic [WB_TMO_CNT_W-1:0] cnt, cnt_nxt;

    assign tmo = (state == GRANT) &&
                 (cnt == WB_TMO_CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_nxt = cnt;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (s_ack_i || s_err_i) begin
                    cnt_nxt = '0;
                end else if (stb_raw) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    logic tmo_unused;

    assign tmo        = 1'b0;
    assign tmo_unused = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        stb_raw   = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_dat_o   = '0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                    gnt_nxt   = pick_gnt;
                    ptr_nxt   = pick_idx;
                end
            end
            GRANT: begin
                stb_raw = m_stb_i[ptr];
                s_cyc_o = m_cyc_i[ptr];
                s_stb_o = stb_raw & ~tmo;
                s_we_o  = m_we_i[ptr];
                s_adr_o = adr_a[ptr];
                s_dat_o = dat_a[ptr];
                s_sel_o = sel_a[ptr];
                m_dat_o = s_dat_i;
                // A late ack after the watchdog fires
                // must not reach the master.
                if (tmo) begin
                    m_err_o[ptr] = 1'b1;
                end else begin
                    m_ack_o[ptr] = s_ack_i;
                    m_err_o[ptr] = s_err_i;
                end
                if (!m_cyc_i[ptr] || tmo) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
        end
    end

    assign gnt_o = gnt;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter.
// Two masters; watchdog scenario when WB_ARB_TIMEOUT_EN.
module tb_wb_rr_arbiter;

    localparam int MN = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [MN-1:0] m_cyc_i, m_stb_i, m_we_i;
    logic [MN*AW-1:0] m_adr_i;
    logic [MN*DW-1:0] m_dat_i;
    logic [MN*SW-1:0] m_sel_i;
    logic [MN-1:0] m_ack_o, m_err_o;
    logic [DW-1:0] m_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic          s_ack_i, s_err_i;
    logic [DW-1:0] s_dat_i;
    logic [MN-1:0] gnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [AW-1:0] A0 = 32'h0000_0004;
    localparam logic [AW-1:0] A1 = 32'h1000_0010;

    always #5 clk_i = ~clk_i;

    wb_rr_arbiter #(
        .MASTER_NUM     (MN),
        .ADR_WIDTH      (AW),
        .DAT_WIDTH      (DW),
        .SEL_WIDTH      (SW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_dat_i (s_dat_i),
        .gnt_o   (gnt_o)
    );

    task automatic test_reset();
        rst_i   = 1'b0;
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        m_we_i  = 2'b01;
        m_adr_i = {A1, A0};
        m_dat_i = {32'hAAAA_0001, 32'h5555_0000};
        m_sel_i = {4'hC, 4'h3};
        s_ack_i = 1'b1;
        s_err_i = 1'b1;
        s_dat_i = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk_i);
        n_chk++;
        if (gnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_gnt: got %b want 00", gnt_o);
        end
        n_chk++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_s_ctl: got %b want 000",
                     {s_cyc_o, s_stb_o, s_we_o});
        end
        n_chk++;
        if ({s_adr_o, s_dat_o, s_sel_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_s_bus: got %h %h %h want 0",
                     s_adr_o, s_dat_o, s_sel_o);
        end
        n_chk++;
        if ({m_ack_o, m_err_o, m_dat_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_m_ret: got %b %b %h want 0",
                     m_ack_o, m_err_o, m_dat_o);
        end
        rst_i   = 1'b1;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = '0;
        @(negedge clk_i);
        n_chk++;
        if (gnt_o !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_exit_gnt: got %b want 10", gnt_o);
        end
        n_chk++;
        if (s_adr_o !== A1) begin
            n_fail++;
            $display("FAIL rst_exit_adr: got %h want %h",
                     s_adr_o, A1);
        end
        n_chk++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 7'b110_1100)
        begin
            n_fail++;
            $display("FAIL rst_exit_ctl: got %b want 1101100",
                     {s_cyc_o, s_stb_o, s_we_o, s_sel_o});
        end
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        @(negedge clk_i);
        n_chk++;
        if (gnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_release: got %b want 00", gnt_o);
        end
    endtask

    task automatic test_single_read();
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        m_we_i  = 2'b00;
        @(negedge clk_i);
        n_chk++;
        if (gnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_gnt: got %b want 01", gnt_o);
        end
        n_chk++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o} !=
            {3'b110, A0}) begin
            n_fail++;
            $display("FAIL rd_bus: got %b %h want 110 %h",
                     {s_cyc_o, s_stb_o, s_we_o}, s_adr_o, A0);
        end
        n_chk++;
        if (m_ack_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_no_ack: got %b want 00", m_ack_o);
        end
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEAD_BEEF;
        #1;
        n_chk++;
        if (m_ack_o !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_ack: got %b want 01", m_ack_o);
        end
        n_chk++;
        if (m_dat_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rd_dat: got %h want deadbeef", m_dat_o);
        end
        @(negedge clk_i);
        s_ack_i = 1'b0;
        s_dat_i = '0;
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        #1;
        n_chk++;
        if (m_ack_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_ack_end: got %b want 00", m_ack_o);
        end
        @(negedge clk_i);
        n_chk++;
        if (gnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_release: got %b want 00", gnt_o);
        end
    endtask

    task automatic test_back_to_back();
        int            w;
        logic [MN-1:0] exp_g;
        w       = 1;
        m_stb_i = 2'b11;
        for (int r = 0; r < 4; r++) begin
            exp_g = 2'b01 << w;
            n_chk++;
            if (gnt_o !== 2'b00) begin
                n_fail++;
                $display("FAIL b2b_bubble r%0d: got %b want 00",
                         r, gnt_o);
            end
            m_cyc_i = 2'b11;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk_i);
                n_chk++;
                if (gnt_o !== exp_g) begin
                    n_fail++;
                    $display("FAIL b2b_gnt r%0d c%0d: got %b want %b",
                             r, c, gnt_o, exp_g);
                end
                if (c == 3) begin
                    s_ack_i = 1'b1;
                    #1;
                    n_chk++;
                    if (m_ack_o !== exp_g) begin
                        n_fail++;
                        $display("FAIL b2b_ack r%0d: got %b want %b",
                                 r, m_ack_o, exp_g);
                    end
                    s_ack_i    = 1'b0;
                    m_cyc_i[w] = 1'b0;
                end
            end
            @(negedge clk_i);
            w = 1 - w;
        end
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        @(negedge clk_i);
        n_chk++;
        if (gnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_end: got %b want 00", gnt_o);
        end
    endtask

    task automatic test_mid_request();
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        @(negedge clk_i);
        n_chk++;
        if (gnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_gnt0: got %b want 01", gnt_o);
        end
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        @(negedge clk_i);
        n_chk++;
        if ({gnt_o, s_adr_o} !== {2'b01, A0}) begin
            n_fail++;
            $display("FAIL mid_hold: got %b %h want 01 %h",
                     gnt_o, s_adr_o, A0);
        end
        s_ack_i = 1'b1;
        #1;
        n_chk++;
        if (m_ack_o !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_ack: got %b want 01", m_ack_o);
        end
        s_ack_i = 1'b0;
        @(negedge clk_i);
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
        @(negedge clk_i);
        n_chk++;
        if (gnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_bubble: got %b want 00", gnt_o);
        end
        @(negedge clk_i);
        n_chk++;
        if ({gnt_o, s_adr_o} !== {2'b10, A1}) begin
            n_fail++;
            $display("FAIL mid_gnt1: got %b %h want 10 %h",
                     gnt_o, s_adr_o, A1);
        end
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        @(negedge clk_i);
        n_chk++;
        if ({gnt_o, s_cyc_o, s_stb_o} !== 4'b0111) begin
            n_fail++;
            $display("FAIL rmid_pre: got %b want 0111",
                     {gnt_o, s_cyc_o, s_stb_o});
        end
        rst_i = 1'b0;
        #1;
        n_chk++;
        if ({gnt_o, s_cyc_o, s_stb_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_drop: got %b want 0000",
                     {gnt_o, s_cyc_o, s_stb_o});
        end
        s_ack_i = 1'b1;
        #1;
        n_chk++;
        if (m_ack_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_ack: got %b want 00", m_ack_o);
        end
        @(negedge clk_i);
        n_chk++;
        if ({m_ack_o, s_cyc_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rmid_hold: got %b want 000",
                     {m_ack_o, s_cyc_o});
        end
        s_ack_i = 1'b0;
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        rst_i   = 1'b1;
        @(negedge clk_i);
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            n_chk++;
            if ({gnt_o, s_stb_o, m_err_o} !== 5'b10_1_00) begin
                n_fail++;
                $display("FAIL tmo_wait c%0d: got %b want 10100",
                         c, {gnt_o, s_stb_o, m_err_o});
            end
        end
        @(negedge clk_i);
        n_chk++;
        if ({s_stb_o, m_err_o} !== 3'b0_10) begin
            n_fail++;
            $display("FAIL tmo_err: got %b want 010",
                     {s_stb_o, m_err_o});
        end
        s_ack_i = 1'b1;
        #1;
        n_chk++;
        if (m_ack_o !== 2'b00) begin
            n_fail++;
            $display("FAIL tmo_late_ack: got %b want 00", m_ack_o);
        end
        s_ack_i = 1'b0;
        @(negedge clk_i);
        n_chk++;
        if ({gnt_o, m_err_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL tmo_release: got %b want 0000",
                     {gnt_o, m_err_o});
        end
        @(negedge clk_i);
        n_chk++;
        if (gnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL tmo_next: got %b want 01", gnt_o);
        end
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        @(negedge clk_i);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_mid_request();
        test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone B4 classic arbiter that shares the single intercon master port between MASTER_NUM bus masters, e.g. the cpu plus a future DMA/debug master.
- Sits between the masters and the intercon's m2i_*/i2m_* port.
- Presents exactly one granted master at a time to the intercon.
- Routes ack/err/dat back only to the granted master.
- Grant is held for the whole cyc (bus-lock) of the winner.

Parameters:
- MASTER_NUM, 2, number of requesting masters (2..8).
- ADR_WIDTH, 32, address width (matches `ADR_WIDTH).
- DAT_WIDTH, 32, data width (matches `DAT_WIDTH).
- SEL_WIDTH, 4, byte-select width (matches `SEL_WIDTH).
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  system clock (syscon_clk_o)
- rst_i  in  1  reset; asynchronous, active-low
- m_cyc_i  in  MASTER_NUM  per-master cyc
- m_stb_i  in  MASTER_NUM  per-master stb
- m_we_i  in  MASTER_NUM  per-master we
- m_adr_i  in  MASTER_NUM*ADR_WIDTH  packed addresses; master 0 in the LSBs
- m_dat_i  in  MASTER_NUM*DAT_WIDTH  packed write data
- m_sel_i  in  MASTER_NUM*SEL_WIDTH  packed byte selects
- m_ack_o  out  MASTER_NUM  per-master ack
- m_err_o  out  MASTER_NUM  per-master err
- m_dat_o  out  DAT_WIDTH  read data, broadcast to all masters
- s_cyc_o  out  1  to intercon m2i_cyc_i
- s_stb_o  out  1  to intercon m2i_stb_i
- s_we_o  out  1  to intercon m2i_we_i
- s_adr_o  out  ADR_WIDTH  to intercon m2i_adr_i
- s_dat_o  out  DAT_WIDTH  to intercon m2i_dat_i
- s_sel_o  out  SEL_WIDTH  to intercon m2i_sel_i
- s_ack_i  in  1  from intercon i2m_ack_o
- s_err_i  in  1  from intercon i2m_err_o
- s_dat_i  in  DAT_WIDTH  from intercon i2m_dat_o
- gnt_o  out  MASTER_NUM  one-hot current grant (debug/LEDs)

Behaviour:

Reset (rst_i low, takes effect asynchronously):
- State = IDLE, gnt_o = 0, rr pointer = 0.
- All s_* outputs = 0, m_ack_o = 0, m_err_o = 0, m_dat_o = 0.
- Reset mid-transfer drops s_cyc_o/s_stb_o immediately. No ack is forwarded.

States: IDLE, GRANT.

IDLE:
- If any m_cyc_i is set, pick the first requester scanning from index ptr+1 upward, wrapping modulo MASTER_NUM.
- On the next edge: gnt_o = one-hot(winner), state = GRANT, ptr = winner.
- Arbitration latency is 1 cycle. If no requester, stay in IDLE.

GRANT:
- s_cyc_o = m_cyc_i[g] & gnt_o valid; s_stb_o = m_stb_i[g].
- s_we_o, s_adr_o, s_dat_o, s_sel_o are combinational muxes of master g's fields.
- m_ack_o[g] = s_ack_i, m_err_o[g] = s_err_i. All other ack/err bits are 0.
- m_dat_o = s_dat_i.
- Pipelining: stb and ack are combinational pass-through, so there is no extra latency once granted.

GRANT to IDLE:
- Taken on the edge where m_cyc_i[g] is sampled low.
- gnt_o clears on that edge, giving one bubble cycle before the next grant. Fairness is guaranteed by the pointer.

Other rules:
- Non-granted masters see ack = err = 0 and simply wait.
- Their stb is ignored; no transfer is lost.
- Simultaneous requests at reset exit: ptr = 0 means master 1 wins first when MASTER_NUM ≥ 2, then master 0.
- A single continuous requester is re-granted after each bubble.
- A granted master that holds cyc forever starves the others. That is by design unless the timeout feature is enabled.
- ptr arithmetic is $clog2(MASTER_NUM) bits, wrapping at MASTER_NUM-1 → 0 (not a power-of-two wrap).

Optional Feature:

Macro: WB_ARB_TIMEOUT_EN

Defined:
- An 8..16-bit counter clears on entering GRANT and on every s_ack_i/s_err_i.
- It increments while s_stb_o=1 without ack/err.
- When it reaches TIMEOUT_CYCLES: m_err_o[g]=1 for exactly one cycle, s_stb_o is forced 0 that cycle, the grant is released, and state = IDLE.
- It does not forward a late s_ack_i to that master.

Undefined:
- No counter. A transfer waits indefinitely.

Decomposition:
- Shared package / `config.v`: ADR/DAT/SEL width defines and the TIMEOUT default constant.
- Grant-state encoding localparams stay local.
- One natural sub-module: rr_pick, a combinational round-robin priority picker. It takes the req vector and ptr and returns a one-hot winner plus a valid flag. It is reusable by a future IRQ controller.

Test Plan:
- Reset: hold rst_i=0 with m_cyc_i=2'b11 → all outputs 0, gnt_o=0. Release → gnt_o=2'b10 one cycle later, s_adr_o = master1 address.
- Single master 0, read at 0x0000_0004, slave acks with 0xDEADBEEF → m_ack_o=2'b01, m_dat_o=0xDEADBEEF, m_ack_o[1]=0 throughout.
- Both masters requesting continuously, 4-cycle transfers each → grants alternate 10,01,10,01 with exactly one idle cycle between grants.
- Master 0 granted and master 1 raises cyc mid-transfer → master 1 gets no ack until master 0 drops cyc, then gnt_o=2'b10 one cycle later.
- Assert rst_i=0 while s_stb_o=1 with an ack pending → s_cyc_o/s_stb_o drop asynchronously and no m_ack_o pulse is seen.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks → m_err_o[g] pulses once at stb cycle 8, then the other master is granted.
